// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: miss-handling stage between the data cache and word-wide memory.
// Moves a dirty victim line out (write-back) and/or a missing line in (refill)
// as word-serial bursts, stalling the cache while a burst is in progress.
module cache_mem_ctrl #(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cache_fill_req,
  input  logic                    cache_wb_req,
  input  logic [31:0]             fill_addr,
  input  logic [31:0]             wb_addr,
  input  logic [BLOCK_SIZE*8-1:0] wb_data,
  output logic                    cache_busy_wait,
  output logic                    fill_valid,
  output logic [BLOCK_SIZE*8-1:0] fill_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [29:0]             mem_address,
  output logic [31:0]             mem_writedata,
  input  logic [31:0]             mem_readdata,
  input  logic                    mem_ack
);

  localparam int WORDS    = BLOCK_SIZE / 4;
  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  localparam int CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  // Clears the in-block word bits of a word address (byte bits [OFF_BITS-1:2]).
  localparam logic [29:0] BASE_MASK = ~30'((1 << (OFF_BITS - 2)) - 1);

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [29:0]             r_wb_base;
  logic [29:0]             r_fill_base;
  logic [BLOCK_SIZE*8-1:0] r_wb_data;
  logic [BLOCK_SIZE*8-1:0] r_fill_data;
  logic [31:0]             r_buf [WORDS];
  logic                    r_pend_fill;

  logic                    w_req;
  logic                    w_last;
  logic [31:0]             w_wb_word [WORDS];
  logic [BLOCK_SIZE*8-1:0] w_line;
  logic                    w_unused;

  assign w_req  = cache_fill_req | cache_wb_req;
  assign w_last = (r_cnt == LAST_WORD);

  // Byte-offset bits inside a word never reach the word-addressed memory.
  assign w_unused = ^{wb_addr[1:0], fill_addr[1:0]};

  // Split the latched victim line into words, and assemble the completed refill
  // line: the word arriving on the final ack bypasses the buffer.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign w_wb_word[gi]        = r_wb_data[32*gi +: 32];
      assign w_line[32*gi +: 32]  = (r_cnt == CNT_W'(gi)) ? mem_readdata : r_buf[gi];
    end
  endgenerate

  assign fill_data = r_fill_data;

  // Memory-side request, stall and fill-valid decode from the current state.
  always_comb begin
    mem_read        = (r_state == S_FILL);
    mem_write       = (r_state == S_WB);
    mem_address     = '0;
    mem_writedata   = '0;
    if (r_state == S_WB) begin
      mem_address   = r_wb_base + 30'(r_cnt);
      mem_writedata = w_wb_word[r_cnt];
    end else if (r_state == S_FILL) begin
      mem_address   = r_fill_base + 30'(r_cnt);
    end
    fill_valid      = (r_state == S_DONE) && r_pend_fill;
    cache_busy_wait = reset_n && ((r_state == S_WB) || (r_state == S_FILL) ||
                                  ((r_state == S_IDLE) && w_req));
  end

  // Burst sequencer: latch request, walk the words on each ack, one DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wb_base   <= '0;
      r_fill_base <= '0;
      r_wb_data   <= '0;
      r_fill_data <= '0;
      r_pend_fill <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wb_base   <= wb_addr[31:2] & BASE_MASK;
            r_fill_base <= fill_addr[31:2] & BASE_MASK;
            r_wb_data   <= wb_data;
            r_pend_fill <= cache_fill_req;
            r_cnt       <= '0;
            r_state     <= cache_wb_req ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= r_pend_fill ? S_FILL : S_DONE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_buf[r_cnt] <= mem_readdata;
            if (w_last) begin
              r_cnt       <= '0;
              r_fill_data <= w_line;
              r_state     <= S_DONE;
            end else begin
              r_cnt       <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: directed bench with a queue-based transaction model that
// is compared against the DUT every cycle, plus literal expectations per test.
module tb_cache_mem_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cache_fill_req;
  logic         cache_wb_req;
  logic [31:0]  fill_addr;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         cache_busy_wait;
  logic         fill_valid;
  logic [127:0] fill_data;
  logic         mem_read;
  logic         mem_write;
  logic [29:0]  mem_address;
  logic [31:0]  mem_writedata;
  logic [31:0]  mem_readdata;
  logic         mem_ack;

  always #5 clk = ~clk;

  cache_mem_ctrl #(.BLOCK_SIZE(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cache_fill_req  (cache_fill_req),
    .cache_wb_req    (cache_wb_req),
    .fill_addr       (fill_addr),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .cache_busy_wait (cache_busy_wait),
    .fill_valid      (fill_valid),
    .fill_data       (fill_data),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_ack         (mem_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] data;
    int          idx;
  } op_t;

  op_t          q[$];
  op_t          m_op;
  int           m_phase = 0;   // 0 idle, 1 burst in progress, 2 completion cycle
  bit           m_fill  = 0;
  logic [31:0]  m_line [4];
  logic [127:0] m_fdata = '0;
  logic [31:0]  m_wbase;
  logic [31:0]  m_fbase;

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_phase = 0;
      m_fill  = 0;
      m_fdata = '0;
    end else begin
      case (m_phase)
        0: if (cache_fill_req || cache_wb_req) begin
          m_wbase = wb_addr & ~32'hF;
          m_fbase = fill_addr & ~32'hF;
          if (cache_wb_req)
            for (int i = 0; i < 4; i++)
              q.push_back('{1'b1, m_wbase[31:2] + 30'(i), wb_data[32*i +: 32], i});
          if (cache_fill_req)
            for (int i = 0; i < 4; i++)
              q.push_back('{1'b0, m_fbase[31:2] + 30'(i), 32'h0, i});
          m_fill  = cache_fill_req;
          m_phase = 1;
        end
        1: if (mem_ack) begin
          m_op = q.pop_front();
          if (!m_op.wr) m_line[m_op.idx] = mem_readdata;
          if (q.size() == 0) begin
            m_phase = 2;
            if (m_fill) m_fdata = {m_line[3], m_line[2], m_line[1], m_line[0]};
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare and logging ----------------
  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t         lg[$];
  int           fv_count    = 0;
  logic [127:0] fv_data     = '0;
  int           overlap_cnt = 0;
  bit           chk_en      = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit          busy_q = (m_phase == 1);
      automatic bit          e_wr   = busy_q && q[0].wr;
      automatic bit          e_rd   = busy_q && !q[0].wr;
      automatic logic [29:0] e_addr = busy_q ? q[0].addr : 30'h0;
      automatic logic [31:0] e_wd   = e_wr ? q[0].data : 32'h0;
      automatic bit          e_busy = reset_n && (busy_q ||
                                      (m_phase == 0 && (cache_fill_req || cache_wb_req)));
      chk("busy", cache_busy_wait, e_busy);
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("mem_address", mem_address, e_addr);
      chk("mem_writedata", mem_writedata, e_wd);
      chk("fill_valid", fill_valid, (m_phase == 2) && m_fill);
      chk("fill_data", fill_data, m_fdata);
      if (mem_read && mem_write) overlap_cnt++;
      if ((mem_read || mem_write) && mem_ack && reset_n)
        lg.push_back('{mem_write, mem_address, mem_writedata});
      if (fill_valid) begin
        fv_count++;
        fv_data = fill_data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] rd_seed     = 32'h0;
  logic [29:0] rd_addr0    = 30'h0;
  logic [29:0] stall_addr  = 30'h0;
  int          stall_left  = 0;

  // One clock: present ack/readdata for the current word, then step past the edge.
  task automatic cyc();
    if (stall_left > 0 && mem_read && mem_address == stall_addr) begin
      mem_ack = 1'b0;
      stall_left--;
      chk("t5_stall_addr", mem_address, stall_addr);
      chk("t5_stall_busy", cache_busy_wait, 1'b1);
    end else begin
      mem_ack = 1'b1;
    end
    mem_readdata = rd_seed + 32'(mem_address - rd_addr0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit f, input bit w, input logic [31:0] fa,
                        input logic [31:0] wa, input logic [127:0] wd,
                        output int done_cyc, output bit fv_at_done);
    int n;
    cache_fill_req = f;
    cache_wb_req   = w;
    fill_addr      = fa;
    wb_addr        = wa;
    wb_data        = wd;
    cyc();
    cache_fill_req = 1'b0;
    cache_wb_req   = 1'b0;
    fill_addr      = $urandom;
    wb_addr        = $urandom;
    wb_data        = {$urandom, $urandom, $urandom, $urandom};
    n = 1;
    while (m_phase != 2 && n < 60) begin
      cyc();
      n++;
    end
    if (m_phase != 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: request fill=%0d wb=%0d never completed", f, w);
    end
    done_cyc   = n;
    fv_at_done = fill_valid;
    $display("[TB] txn fill=%0d wb=%0d fill_addr=%h wb_addr=%h done_cycle=%0d fill_valid=%0d fill_data=%h",
             f, w, fa, wa, n, fv_at_done, fill_data);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    bit fv;
    int fv0;

    // Test 1: reset with toggling inputs
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cache_fill_req = 1'($urandom);
      cache_wb_req   = 1'($urandom);
      fill_addr      = $urandom;
      wb_addr        = $urandom;
      wb_data        = {$urandom, $urandom, $urandom, $urandom};
      mem_ack        = 1'($urandom);
      mem_readdata   = $urandom;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
    end
    chk("t1_busy", cache_busy_wait, 1'b0);
    chk("t1_mem_read", mem_read, 1'b0);
    chk("t1_mem_write", mem_write, 1'b0);
    chk("t1_fill_valid", fill_valid, 1'b0);
    chk("t1_mem_address", mem_address, 30'h0);
    chk("t1_fill_data", fill_data, 128'h0);
    reset_n        = 1'b1;
    cache_fill_req = 1'b0;
    cache_wb_req   = 1'b0;
    cyc();
    chk("t1_idle_read", mem_read, 1'b0);
    chk("t1_idle_write", mem_write, 1'b0);
    chk("t1_idle_busy", cache_busy_wait, 1'b0);

    // Test 2: fill only, block containing 0x104C -> words 0x410..0x413
    lg.delete(); fv0 = fv_count;
    rd_seed = 32'hA0; rd_addr0 = 30'h410;
    do_req(1'b1, 1'b0, 32'h0000_104C, 32'h0, 128'h0, dc, fv);
    chk("t2_done_cycle", 32'(dc), 32'd5);
    chk("t2_fill_valid", fv, 1'b1);
    chk("t2_fv_count", 32'(fv_count - fv0), 32'd1);
    chk("t2_fill_data", fv_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t2_words", 32'(lg.size()), 32'd4);
    for (int i = 0; i < lg.size() && i < 4; i++) begin
      chk("t2_read_dir", lg[i].wr, 1'b0);
      chk("t2_read_addr", lg[i].addr, 30'h410 + 30'(i));
    end

    // Test 3: write-back only
    lg.delete(); fv0 = fv_count;
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_2000,
           128'h44444444_33333333_22222222_11111111, dc, fv);
    chk("t3_done_cycle", 32'(dc), 32'd5);
    chk("t3_no_fill_valid", 32'(fv_count - fv0), 32'd0);
    chk("t3_words", 32'(lg.size()), 32'd4);
    for (int i = 0; i < lg.size() && i < 4; i++) begin
      chk("t3_write_dir", lg[i].wr, 1'b1);
      chk("t3_write_addr", lg[i].addr, 30'h800 + 30'(i));
      chk("t3_write_data", lg[i].data, 32'h11111111 * 32'(i + 1));
    end

    // Test 4: write-back then fill
    lg.delete(); fv0 = fv_count; overlap_cnt = 0;
    rd_seed = 32'hE0; rd_addr0 = 30'hC00;
    do_req(1'b1, 1'b1, 32'h0000_3000, 32'h0000_2000,
           128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, dc, fv);
    chk("t4_done_cycle", 32'(dc), 32'd9);
    chk("t4_fill_valid", fv, 1'b1);
    chk("t4_no_overlap", 32'(overlap_cnt), 32'd0);
    chk("t4_fill_data", fv_data, 128'h000000E3_000000E2_000000E1_000000E0);
    chk("t4_words", 32'(lg.size()), 32'd8);
    for (int i = 0; i < lg.size() && i < 8; i++) begin
      chk("t4_dir", lg[i].wr, (i < 4) ? 1'b1 : 1'b0);
      chk("t4_addr", lg[i].addr, (i < 4) ? 30'h800 + 30'(i) : 30'hC00 + 30'(i - 4));
    end

    // Test 5: three wait cycles on word 2 of a fill
    lg.delete(); fv0 = fv_count;
    rd_seed = 32'hB0; rd_addr0 = 30'h400;
    stall_addr = 30'h402; stall_left = 3;
    do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 128'h0, dc, fv);
    chk("t5_stalls_seen", 32'(stall_left), 32'd0);
    chk("t5_done_cycle", 32'(dc), 32'd8);
    chk("t5_fill_data", fv_data, 128'h000000B3_000000B2_000000B1_000000B0);

    // Test 6: reset during word 1 of a fill, then a fresh fill to 0x0
    fv0 = fv_count;
    rd_seed = 32'h55; rd_addr0 = 30'h1400;
    cache_fill_req = 1'b1;
    fill_addr      = 32'h0000_5000;
    cyc();
    cache_fill_req = 1'b0;
    cyc();
    chk("t6_word1_addr", mem_address, 30'h1401);
    reset_n = 1'b0;
    cyc();
    chk("t6_rst_read", mem_read, 1'b0);
    chk("t6_rst_busy", cache_busy_wait, 1'b0);
    chk("t6_rst_fill_data", fill_data, 128'h0);
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("t6_no_fill_valid", 32'(fv_count - fv0), 32'd0);
    rd_seed = 32'hC0; rd_addr0 = 30'h0;
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 128'h0, dc, fv);
    chk("t6_done_cycle", 32'(dc), 32'd5);
    chk("t6_fill_valid", fv, 1'b1);
    chk("t6_fill_data", fv_data, 128'h000000C3_000000C2_000000C1_000000C0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
